// File: rtl/axis_frame_src.sv
// axis_frame_src
// AXI-Stream test-pattern frame source. Sends NUM_LINE lines of NUM_PIX 8-bit
// pixels into the filter's input port, then pulses done_o. tlast marks the
// last pixel of each line and tuser marks the first pixel of the frame.
// LINE_GAP idle cycles are inserted after every line except the last.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset (aborts a frame at once)
//   start_i        one-cycle pulse, begins a frame when idle
//   mode_i[1:0]    pattern: 0 h-ramp, 1 v-ramp, 2 8x8 checker, 3 constant
//   const_i[7:0]   pixel value used by pattern 3
//   axis_tready_i  downstream ready
//   axis_tdata_o   pixel
//   axis_tvalid_o  beat valid
//   axis_tkeep_o   byte qualifier, follows axis_tvalid_o
//   axis_tlast_o   last pixel of a line
//   axis_tuser_o   first pixel of the frame
//   busy_o         frame in progress
//   done_o         one-cycle pulse after the final beat is accepted
module axis_frame_src #(
  parameter int NUM_PIX  = 640,
  parameter int NUM_LINE = 512,
  parameter int LINE_GAP = 100
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  logic [7:0] const_i,
  input  logic       axis_tready_i,
  output logic [7:0] axis_tdata_o,
  output logic       axis_tvalid_o,
  output logic       axis_tkeep_o,
  output logic       axis_tlast_o,
  output logic       axis_tuser_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int PW = (NUM_PIX  > 1) ? $clog2(NUM_PIX)      : 1;
  localparam int LW = (NUM_LINE > 1) ? $clog2(NUM_LINE)     : 1;
  localparam int GW = (LINE_GAP > 0) ? $clog2(LINE_GAP + 1) : 1;

  localparam logic [PW-1:0] PIX_LAST  = PW'(NUM_PIX - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(NUM_LINE - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(LINE_GAP - 1);
  localparam logic          ONE_PIX   = (NUM_PIX == 1);

  typedef enum logic [1:0] {IDLE, LINE, GAP, DONE} state_t;

  state_t        state_q;
  logic [PW-1:0] pix_q;
  logic [LW-1:0] line_q;
  logic [GW-1:0] gap_q;
  logic [1:0]    mode_q;
  logic [7:0]    const_q;
  logic [7:0]    tdata_q;
  logic          tvalid_q;
  logic          tlast_q;
  logic          tuser_q;
  logic          busy_q;
  logic          done_q;

  logic [PW-1:0] pixNext_d;
  logic [LW-1:0] lineNext_d;
  logic          accept_d;

  // Pixel value for coordinate (p, l); only the low 8 bits of each index matter.
  function automatic logic [7:0] pattern(input logic [7:0] p, input logic [7:0] l,
                                         input logic [1:0] m, input logic [7:0] c);
    logic [7:0] r;
    case (m)
      2'd0:    r = p;
      2'd1:    r = l;
      2'd2:    r = (p[3] ^ l[3]) ? 8'hFF : 8'h00;
      default: r = c;
    endcase
    return r;
  endfunction

  assign pixNext_d  = pix_q + PW'(1);
  assign lineNext_d = line_q + LW'(1);
  assign accept_d   = tvalid_q & axis_tready_i;

  // The output beat is always computed one cycle ahead, from the coordinate
  // that will be presented next, so every output comes straight off a flop and
  // a new beat follows an accepted one with no bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pix_q    <= '0;
      line_q   <= '0;
      gap_q    <= '0;
      mode_q   <= '0;
      const_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= LINE;
            mode_q   <= mode_i;
            const_q  <= const_i;
            pix_q    <= '0;
            line_q   <= '0;
            busy_q   <= 1'b1;
            tvalid_q <= 1'b1;
            tuser_q  <= 1'b1;
            tlast_q  <= ONE_PIX;
            tdata_q  <= pattern(8'd0, 8'd0, mode_i, const_i);
          end
        end
        LINE: begin
          if (accept_d) begin
            tuser_q <= 1'b0;
            if (pix_q == PIX_LAST) begin
              pix_q <= '0;
              if (line_q == LINE_LAST) begin
                state_q  <= DONE;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end else if (LINE_GAP == 0) begin
                // No gap: first pixel of the next line goes out immediately.
                line_q  <= lineNext_d;
                tlast_q <= ONE_PIX;
                tdata_q <= pattern(8'd0, 8'(lineNext_d), mode_q, const_q);
              end else begin
                state_q  <= GAP;
                gap_q    <= '0;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
              end
            end else begin
              pix_q   <= pixNext_d;
              tlast_q <= (pixNext_d == PIX_LAST);
              tdata_q <= pattern(8'(pixNext_d), 8'(line_q), mode_q, const_q);
            end
          end
        end
        GAP: begin
          // tvalid is raised on the flop update of the last gap cycle so that
          // exactly LINE_GAP cycles show tvalid low; tready is not looked at.
          if (gap_q == GAP_LAST) begin
            state_q  <= LINE;
            line_q   <= lineNext_d;
            tvalid_q <= 1'b1;
            tlast_q  <= ONE_PIX;
            tdata_q  <= pattern(8'd0, 8'(lineNext_d), mode_q, const_q);
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign axis_tdata_o  = tdata_q;
  assign axis_tvalid_o = tvalid_q;
  assign axis_tkeep_o  = tvalid_q;
  assign axis_tlast_o  = tlast_q;
  assign axis_tuser_o  = tuser_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
